// File: rtl/axis_inet_checksum_pkg.sv
// Shared definitions for the AXI-Stream internet checksum engine.
package axis_inet_checksum_pkg;

   typedef enum logic {
      MODE_GEN = 1'b0,
      MODE_VER = 1'b1
   } csum_mode_e;

   // Folded sum of a frame that already carries its correct checksum.
   localparam logic [15:0] CSUM_OK_VALUE = 16'hFFFF;

   function automatic int acc_w_min(input int data_w);
      return 16 + $clog2(data_w / 16) + 1;
   endfunction

endpackage

// File: rtl/inet_csum_lane_sum.sv
// Combinational adder tree over the 16-bit words of one masked beat.
module inet_csum_lane_sum #(
   parameter int DATA_W = 64,
   parameter int SUM_W  = 16 + $clog2(DATA_W / 16)
) (
   input  logic [DATA_W-1:0] lanes,
   output logic [SUM_W-1:0]  beat_sum
);
   localparam int NW = DATA_W / 16;

   // Lane 2j is the earlier wire byte, so it forms the high half of word j.
   function automatic logic [SUM_W-1:0] tree_sum(input logic [DATA_W-1:0] d);
      logic [SUM_W-1:0] node [NW];
      for (int j = 0; j < NW; j++)
         node[j] = SUM_W'({d[16*j +: 8], d[16*j+8 +: 8]});
      for (int s = 1; s < NW; s = s * 2)
         for (int j = 0; j + s < NW; j = j + 2 * s)
            node[j] = node[j] + node[j+s];
      return node[0];
   endfunction

   assign beat_sum = tree_sum(lanes);

endmodule

// File: rtl/axis_inet_checksum.sv
// RFC 1071 checksum engine: lane masking, per-beat sum, end-around accumulator, fold.
module axis_inet_checksum
   import axis_inet_checksum_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int KEEP_W = DATA_W / 8,
   parameter int OFF_W  = 16,
   parameter int ACC_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [DATA_W-1:0] i_s_axis_tdata,
   input  logic [KEEP_W-1:0] i_s_axis_tkeep,
   input  logic              i_s_axis_tvalid,
   input  logic              i_s_axis_tlast,
   output logic              o_s_axis_tready,
   input  logic [15:0]       i_seed,
   input  logic [OFF_W-1:0]  i_start_off,
   input  logic              i_mode,
   output logic [15:0]       o_csum,
   output logic              o_csum_ok,
   output logic              o_csum_valid,
   input  logic              i_csum_ready
);
   localparam int SUM_W = 16 + $clog2(DATA_W / 16);
   localparam int IDX_W = OFF_W + 1;

   if (DATA_W % 16 != 0 || ACC_W < acc_w_min(DATA_W)) begin : g_bad_params
      $error("axis_inet_checksum: DATA_W must be a multiple of 16 and ACC_W wide enough");
   end

   logic              adv, accept;
   logic              first_beat;
   logic [OFF_W-1:0]  byte_cnt, off_q, base, off_cur;
   csum_mode_e        mode_q, mode_cur;
   logic [IDX_W-1:0]  cnt_next;
   logic [DATA_W-1:0] lanes;
   logic [SUM_W-1:0]  beat_sum;

   logic              s1_valid, s1_first, s1_last;
   csum_mode_e        s1_mode;
   logic [15:0]       s1_seed;
   logic [SUM_W-1:0]  s1_sum;

   logic              s2_last;
   csum_mode_e        s2_mode;
   logic [ACC_W-1:0]  acc;

   logic [16:0]       f1;
   logic [15:0]       f;

   assign adv             = !o_csum_valid || i_csum_ready;
   assign o_s_axis_tready = adv;
   assign accept          = i_s_axis_tvalid && adv;

   // Offset and mode are taken live on a first beat, then held for the frame.
   assign base     = first_beat ? '0 : byte_cnt;
   assign off_cur  = first_beat ? i_start_off : off_q;
   assign mode_cur = first_beat ? csum_mode_e'(i_mode) : mode_q;
   assign cnt_next = {1'b0, base} + IDX_W'(KEEP_W);

   always_comb begin
      lanes = '0;
      for (int k = 0; k < KEEP_W; k++)
         if (i_s_axis_tkeep[k] && ({1'b0, base} + IDX_W'(k) >= {1'b0, off_cur}))
            lanes[8*k +: 8] = i_s_axis_tdata[8*k +: 8];
   end

   inet_csum_lane_sum #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_lane_sum (
      .lanes    (lanes),
      .beat_sum (beat_sum)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         first_beat <= 1'b1;
         byte_cnt   <= '0;
         off_q      <= '0;
         mode_q     <= MODE_GEN;
      end else if (accept) begin
         first_beat <= i_s_axis_tlast;
         byte_cnt   <= cnt_next[OFF_W] ? '1 : cnt_next[OFF_W-1:0];
         off_q      <= off_cur;
         mode_q     <= mode_cur;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_mode  <= MODE_GEN;
         s1_seed  <= '0;
         s1_sum   <= '0;
      end else if (adv) begin
         s1_valid <= accept;
         s1_first <= first_beat;
         s1_last  <= i_s_axis_tlast;
         s1_mode  <= mode_cur;
         s1_seed  <= i_seed;
         s1_sum   <= beat_sum;
      end
   end

   // End-around accumulation keeps acc bounded for any frame length.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s2_last <= 1'b0;
         s2_mode <= MODE_GEN;
         acc     <= '0;
      end else if (adv) begin
         s2_last <= s1_valid && s1_last;
         s2_mode <= s1_mode;
         if (s1_valid)
            acc <= s1_first ? ACC_W'(s1_seed) + ACC_W'(s1_sum)
                            : ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]) + ACC_W'(s1_sum);
      end
   end

   assign f1 = {1'b0, acc[15:0]} + 17'(acc[ACC_W-1:16]);
   assign f  = f1[15:0] + 16'(f1[16]);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_csum       <= '0;
         o_csum_ok    <= 1'b0;
         o_csum_valid <= 1'b0;
      end else if (adv) begin
         if (s2_last) begin
            o_csum       <= ~f;
            o_csum_ok    <= (s2_mode == MODE_VER) && (f == CSUM_OK_VALUE);
            o_csum_valid <= 1'b1;
         end else begin
            o_csum_valid <= 1'b0;
         end
      end
   end

endmodule
